// File: rtl/move_list_host.sv
`default_nettype none
// ============================================================================
// Module      : move_list_host
// Description : Avalon-MM master that hands a 256-bit board to a move
//               generator through a mailbox, polls for completion, reads back
//               the generated move list one word at a time and streams the
//               moves out over a valid/ready interface.
// Revision    : 1.0  initial release
// ============================================================================
module move_list_host #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 15,
   parameter int POLL_LIMIT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  go,
   input  logic [255:0]          board,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [7:0]            move_count,
   output logic                  move_valid,
   output logic [17:0]           move_data,
   input  logic                  move_ready,
   output logic [ADDR_WIDTH-1:0] master_address,
   output logic                  master_read,
   output logic                  master_write,
   output logic [DATA_WIDTH-1:0] master_writedata,
   input  logic [DATA_WIDTH-1:0] master_readdata,
   output logic [3:0]            master_byteenable,
   input  logic                  master_waitrequest,
   input  logic                  master_readdatavalid
);

   // Mailbox map (word addresses)
   localparam logic [ADDR_WIDTH-1:0] c_addrCtrl  = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] c_addrBoard = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] c_addrCount = ADDR_WIDTH'(16);
   localparam logic [ADDR_WIDTH-1:0] c_addrMoves = ADDR_WIDTH'(17);
   localparam int                    c_pollW     = $clog2(POLL_LIMIT + 1);

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_WR_BOARD = 4'd1,
      ST_WR_START = 4'd2,
      ST_POLL     = 4'd3,
      ST_CNT      = 4'd4,
      ST_MV_RD    = 4'd5,
      ST_MV_OUT   = 4'd6,
      ST_WR_CLEAR = 4'd7,
      ST_FIN      = 4'd8
   } state_t;

   state_t               r_state;
   logic [255:0]         r_board;
   logic [2:0]           r_wordIdx;
   logic [c_pollW-1:0]   r_pollCnt;
   logic [7:0]           r_moveIdx;
   logic                 r_rdPending;

   logic                 w_cmdDone;
   logic                 w_rdAccept;
   logic                 w_rdData;
   logic [2:0]           w_nextWord;
   logic [31:0]          w_nextSlice;
   logic [8:0]           w_nextMoveIdx;
   logic                 w_pollLimitHit;
   logic                 w_unused;

   // A command completes on the first cycle its strobe meets a low waitrequest
   assign w_cmdDone      = (master_read | master_write) & ~master_waitrequest;
   assign w_rdAccept     = master_read & ~master_waitrequest;
   // Read data is only meaningful while our own read is outstanding
   assign w_rdData       = r_rdPending & master_readdatavalid;
   assign w_nextWord     = r_wordIdx + 3'd1;
   assign w_nextSlice    = r_board[{w_nextWord, 5'b00000} +: 32];
   assign w_nextMoveIdx  = {1'b0, r_moveIdx} + 9'd1;
   assign w_pollLimitHit = (r_pollCnt >= c_pollW'(POLL_LIMIT));

   assign master_byteenable = 4'hF;

   // Word 0 of the board goes out straight from the input on go, so the
   // registered copy of that slice is never read; upper readdata bits are
   // don't-care for every mailbox word.
   assign w_unused = &{1'b0, r_board[31:0], master_readdata[DATA_WIDTH-1:18]};

   // Transaction sequencer: walks the mailbox protocol and owns every registered output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= ST_IDLE;
         r_board          <= '0;
         r_wordIdx        <= '0;
         r_pollCnt        <= '0;
         r_moveIdx        <= '0;
         r_rdPending      <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         timeout          <= 1'b0;
         move_count       <= '0;
         move_valid       <= 1'b0;
         move_data        <= '0;
         master_address   <= '0;
         master_read      <= 1'b0;
         master_write     <= 1'b0;
         master_writedata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (go) begin
                  r_board          <= board;
                  r_wordIdx        <= '0;
                  timeout          <= 1'b0;
                  busy             <= 1'b1;
                  master_write     <= 1'b1;
                  master_address   <= c_addrBoard;
                  master_writedata <= DATA_WIDTH'(board[31:0]);
                  r_state          <= ST_WR_BOARD;
               end
            end

            ST_WR_BOARD: begin
               if (w_cmdDone) begin
                  if (r_wordIdx == 3'd7) begin
                     master_address   <= c_addrCtrl;
                     master_writedata <= DATA_WIDTH'(32'h1);
                     r_state          <= ST_WR_START;
                  end else begin
                     r_wordIdx        <= w_nextWord;
                     master_address   <= c_addrBoard + ADDR_WIDTH'(w_nextWord);
                     master_writedata <= DATA_WIDTH'(w_nextSlice);
                  end
               end
            end

            ST_WR_START: begin
               if (w_cmdDone) begin
                  master_write   <= 1'b0;
                  master_read    <= 1'b1;
                  master_address <= c_addrCtrl;
                  r_pollCnt      <= '0;
                  r_state        <= ST_POLL;
               end
            end

            ST_POLL: begin
               if (w_rdAccept) begin
                  master_read <= 1'b0;
                  r_rdPending <= 1'b1;
                  r_pollCnt   <= r_pollCnt + c_pollW'(1);
               end else if (w_rdData) begin
                  r_rdPending <= 1'b0;
                  if (master_readdata[1]) begin
                     master_read    <= 1'b1;
                     master_address <= c_addrCount;
                     r_state        <= ST_CNT;
                  end else if (w_pollLimitHit) begin
                     timeout          <= 1'b1;
                     master_write     <= 1'b1;
                     master_address   <= c_addrCtrl;
                     master_writedata <= '0;
                     r_state          <= ST_WR_CLEAR;
                  end else begin
                     master_read <= 1'b1;
                  end
               end
            end

            ST_CNT: begin
               if (w_rdAccept) begin
                  master_read <= 1'b0;
                  r_rdPending <= 1'b1;
               end else if (w_rdData) begin
                  r_rdPending <= 1'b0;
                  move_count  <= master_readdata[7:0];
                  if (master_readdata[7:0] == 8'd0) begin
                     master_write     <= 1'b1;
                     master_address   <= c_addrCtrl;
                     master_writedata <= '0;
                     r_state          <= ST_WR_CLEAR;
                  end else begin
                     r_moveIdx      <= '0;
                     master_read    <= 1'b1;
                     master_address <= c_addrMoves;
                     r_state        <= ST_MV_RD;
                  end
               end
            end

            ST_MV_RD: begin
               if (w_rdAccept) begin
                  master_read <= 1'b0;
                  r_rdPending <= 1'b1;
               end else if (w_rdData) begin
                  r_rdPending <= 1'b0;
                  move_data   <= master_readdata[17:0];
                  move_valid  <= 1'b1;
                  r_state     <= ST_MV_OUT;
               end
            end

            ST_MV_OUT: begin
               // Next read is only launched once the held move has been taken
               if (move_ready) begin
                  move_valid <= 1'b0;
                  r_moveIdx  <= w_nextMoveIdx[7:0];
                  if (w_nextMoveIdx == {1'b0, move_count}) begin
                     master_write     <= 1'b1;
                     master_address   <= c_addrCtrl;
                     master_writedata <= '0;
                     r_state          <= ST_WR_CLEAR;
                  end else begin
                     master_read    <= 1'b1;
                     master_address <= c_addrMoves + ADDR_WIDTH'(w_nextMoveIdx);
                     r_state        <= ST_MV_RD;
                  end
               end
            end

            ST_WR_CLEAR: begin
               if (w_cmdDone) begin
                  master_write <= 1'b0;
                  done         <= 1'b1;
                  r_state      <= ST_FIN;
               end
            end

            ST_FIN: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               busy         <= 1'b0;
               done         <= 1'b0;
               master_read  <= 1'b0;
               master_write <= 1'b0;
               r_rdPending  <= 1'b0;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_move_list_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_list_host
// Description : Self-checking bench for move_list_host: Avalon slave model
//               with configurable waitrequest/latency, move sink with
//               backpressure, and a command-log reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_move_list_host;

   localparam int DW = 32;
   localparam int AW = 15;
   localparam int PL = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           go = 1'b0;
   logic [255:0]   board = '0;
   logic           busy, done, timeout;
   logic [7:0]     move_count;
   logic           move_valid;
   logic [17:0]    move_data;
   logic           move_ready = 1'b0;
   logic [AW-1:0]  master_address;
   logic           master_read, master_write;
   logic [DW-1:0]  master_writedata;
   logic [DW-1:0]  master_readdata = '0;
   logic [3:0]     master_byteenable;
   logic           master_waitrequest = 1'b0;
   logic           master_readdatavalid = 1'b0;

   always #5 clk = ~clk;

   move_list_host #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POLL_LIMIT(PL)) dut (
      .clk(clk), .reset(reset), .go(go), .board(board),
      .busy(busy), .done(done), .timeout(timeout), .move_count(move_count),
      .move_valid(move_valid), .move_data(move_data), .move_ready(move_ready),
      .master_address(master_address), .master_read(master_read),
      .master_write(master_write), .master_writedata(master_writedata),
      .master_readdata(master_readdata), .master_byteenable(master_byteenable),
      .master_waitrequest(master_waitrequest),
      .master_readdatavalid(master_readdatavalid)
   );

   typedef struct {
      int waitCyc;
      int latency;
      int pollsDone;     // poll number that first returns bit1=1, 0 = never
      int count;
      int readyStall;
      int goAgain;       // cycle after go for a stray go pulse, -1 = none
      bit fixedMoves;
      bit expTimeout;
      int expPolls;
      int expDone;
   } scen_t;

   int nChecks = 0;
   int nPass   = 0;

   // slave / sink configuration and state
   int          cfgWait = 0, cfgLat = 1, cfgPolls = 1, cfgCount = 0, cfgStall = 0;
   int          moveLimit = 1000;
   bit          injectStale = 1'b0;
   logic [17:0] moveMem [256];
   logic [17:0] fixedMv [3] = '{18'h00A41, 18'h00B52, 18'h3FFFF};
   int          stallCnt = 0, readyCnt = 0, rdDelay = 0, pollIdx = 0;
   int          doneCnt = 0, protoErr = 0;
   bit          rdPending = 1'b0, prevHold = 1'b0, prevMvHold = 1'b0;
   logic [AW-1:0] prevAddr = '0;
   logic [DW-1:0] prevData = '0;
   logic        prevRd = 1'b0, prevWr = 1'b0;
   logic [17:0] prevMv = '0;
   logic [DW-1:0] rdData = '0;
   logic [63:0] gotQ[$];
   logic [17:0] gotMoves[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [63:0] enc(input logic wr, input int addr, input logic [31:0] d);
      return {15'd0, wr, addr[15:0], d};
   endfunction

   // Mailbox memory behaviour for one accepted command
   function automatic void acceptCmd();
      logic [DW-1:0] d;
      int a;
      a = int'(master_address);
      if (master_write) begin
         gotQ.push_back(enc(1'b1, a, master_writedata));
      end else begin
         gotQ.push_back(enc(1'b0, a, 32'h0));
         d = $urandom;
         if (a == 0) begin
            pollIdx++;
            d[1] = (cfgPolls != 0) && (pollIdx >= cfgPolls);
         end else if (a == 16) begin
            d[7:0] = cfgCount[7:0];
         end else if (a >= 17 && a < 17 + 256) begin
            d[17:0] = moveMem[a - 17];
         end
         rdData    = d;
         rdPending = 1'b1;
         rdDelay   = cfgLat;
      end
   endfunction

   // Slave, sink and protocol monitor; everything happens on the falling edge
   always @(negedge clk) begin
      if (reset) begin
         if (master_read && master_write) protoErr++;
         if (master_read && (move_valid || rdPending)) protoErr++;
         if (prevHold && (master_address !== prevAddr || master_writedata !== prevData ||
                          master_read !== prevRd || master_write !== prevWr)) protoErr++;
         if (prevMvHold && (!move_valid || move_data !== prevMv)) protoErr++;
         if (done) doneCnt++;
      end
      master_readdatavalid = 1'b0;
      if (rdPending) begin
         if (rdDelay <= 1) begin
            master_readdatavalid = 1'b1;
            master_readdata      = rdData;
            rdPending            = 1'b0;
         end else begin
            rdDelay--;
         end
      end
      if (injectStale) begin
         master_readdatavalid = 1'b1;
         master_readdata      = $urandom;
      end
      if (!reset) begin
         rdPending = 1'b0; prevHold = 1'b0; prevMvHold = 1'b0;
         stallCnt = 0; readyCnt = 0;
         master_waitrequest = 1'b0; move_ready = 1'b0;
      end else begin
         if (master_read || master_write) begin
            if (stallCnt < cfgWait) begin
               master_waitrequest = 1'b1; stallCnt++;
            end else begin
               master_waitrequest = 1'b0; stallCnt = 0; acceptCmd();
            end
         end else begin
            master_waitrequest = 1'b0; stallCnt = 0;
         end
         prevHold = (master_read || master_write) && master_waitrequest;
         prevAddr = master_address; prevData = master_writedata;
         prevRd = master_read; prevWr = master_write;
         if (move_valid && gotMoves.size() < moveLimit && readyCnt >= cfgStall) begin
            move_ready = 1'b1;
            gotMoves.push_back(move_data);
            readyCnt = 0;
         end else begin
            move_ready = 1'b0;
            readyCnt = move_valid ? readyCnt + 1 : 0;
         end
         prevMvHold = move_valid && !move_ready;
         prevMv     = move_data;
      end
   end

   task automatic runScenario(input scen_t s, input string tag);
      logic [255:0] brd;
      logic [63:0]  expQ[$];
      logic [17:0]  expMv[$];
      int cyc, polls, nPollsExp;
      bit expTo;
      for (int k = 0; k < 8; k++) brd[32*k +: 32] = $urandom;
      for (int i = 0; i < 256; i++) moveMem[i] = (s.fixedMoves && i < 3) ? fixedMv[i] : 18'($urandom);
      cfgWait = s.waitCyc; cfgLat = s.latency; cfgPolls = s.pollsDone;
      cfgCount = s.count; cfgStall = s.readyStall; moveLimit = 1000;
      pollIdx = 0; doneCnt = 0; protoErr = 0;
      gotQ.delete(); gotMoves.delete();

      // reference: the command sequence the mailbox protocol must produce
      expTo     = (s.pollsDone == 0) || (s.pollsDone > PL);
      nPollsExp = expTo ? PL : s.pollsDone;
      for (int k = 0; k < 8; k++) expQ.push_back(enc(1'b1, 2 + k, brd[32*k +: 32]));
      expQ.push_back(enc(1'b1, 0, 32'h1));
      for (int p = 0; p < nPollsExp; p++) expQ.push_back(enc(1'b0, 0, 32'h0));
      if (!expTo) begin
         expQ.push_back(enc(1'b0, 16, 32'h0));
         for (int i = 0; i < s.count; i++) begin
            expQ.push_back(enc(1'b0, 17 + i, 32'h0));
            expMv.push_back(moveMem[i]);
         end
      end
      expQ.push_back(enc(1'b1, 0, 32'h0));

      @(negedge clk); board = brd; go = 1'b1;
      @(negedge clk); go = 1'b0; board = ~brd;
      check($sformatf("%s busy after go", tag), busy, 1);
      check($sformatf("%s timeout cleared by go", tag), timeout, 0);
      cyc = 0;
      while (doneCnt == 0 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         go = (cyc == s.goAgain);
      end
      go = 1'b0;
      check($sformatf("%s finished in budget", tag), cyc < 4000, 1);
      if (cyc >= 4000) begin
         reset = 1'b0; @(negedge clk); reset = 1'b1;
      end
      repeat (3) @(negedge clk);

      check($sformatf("%s done pulses", tag), doneCnt, s.expDone);
      check($sformatf("%s timeout flag", tag), timeout, s.expTimeout);
      check($sformatf("%s busy idle", tag), busy, 0);
      if (!s.expTimeout) check($sformatf("%s move_count", tag), move_count, s.count);
      polls = 0;
      foreach (gotQ[i]) if (gotQ[i][47:32] == 16'd0 && gotQ[i][48] == 1'b0) polls++;
      check($sformatf("%s poll reads", tag), polls, s.expPolls);
      check($sformatf("%s command count", tag), gotQ.size(), expQ.size());
      for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
         check($sformatf("%s cmd[%0d]", tag, i), gotQ[i], expQ[i]);
      check($sformatf("%s move transfers", tag), gotMoves.size(), expMv.size());
      for (int i = 0; i < expMv.size() && i < gotMoves.size(); i++)
         check($sformatf("%s move[%0d]", tag, i), gotMoves[i], expMv[i]);
      check($sformatf("%s protocol errors", tag), protoErr, 0);
   endtask

   // Reset hits while the third of five moves is being held, then a stale
   // readdatavalid arrives once reset is released.
   task automatic resetMidMove();
      logic [255:0] brd;
      int cyc;
      for (int k = 0; k < 8; k++) brd[32*k +: 32] = $urandom;
      for (int i = 0; i < 256; i++) moveMem[i] = 18'($urandom);
      cfgWait = 1; cfgLat = 2; cfgPolls = 1; cfgCount = 5; cfgStall = 0; moveLimit = 2;
      pollIdx = 0; doneCnt = 0; protoErr = 0;
      gotQ.delete(); gotMoves.delete();
      @(negedge clk); board = brd; go = 1'b1;
      @(negedge clk); go = 1'b0;
      cyc = 0;
      while (!(move_valid && gotMoves.size() == 2) && cyc < 3000) begin
         @(negedge clk); cyc++;
      end
      check("rst reached third move", cyc < 3000, 1);
      #2 reset = 1'b0;
      #1;
      check("rst async clear status", {busy, done, timeout, move_valid, move_data, move_count}, 0);
      check("rst async clear bus", {master_read, master_write, master_address, master_writedata}, 0);
      @(negedge clk);
      #2 reset = 1'b1; injectStale = 1'b1;
      @(negedge clk);
      #2 injectStale = 1'b0;
      repeat (3) @(negedge clk);
      check("rst idle after stale rdv", {busy, done, timeout, move_valid, move_data, move_count}, 0);
      check("rst bus idle after stale rdv", {master_read, master_write, master_address, master_writedata}, 0);
      check("rst moves before reset", gotMoves.size(), 2);
      check("rst no done pulse", doneCnt, 0);
      moveLimit = 1000;
   endtask

   initial begin
      scen_t tbl [6];
      //            wait lat polls cnt stall goAgain fixed expTo expPolls expDone
      tbl[0] = '{0, 1, 4, 3, 0, -1, 1'b1, 1'b0, 4, 1};   // nominal
      tbl[1] = '{5, 2, 2, 3, 4, -1, 1'b1, 1'b0, 2, 1};   // backpressure
      tbl[2] = '{0, 1, 1, 0, 0, -1, 1'b0, 1'b0, 1, 1};   // zero count
      tbl[3] = '{1, 1, 0, 3, 0, -1, 1'b0, 1'b1, 4, 1};   // never done: timeout
      tbl[4] = '{2, 3, 3, 4, 1,  5, 1'b0, 1'b0, 3, 1};   // go while busy
      tbl[5] = '{0, 4, 5, 2, 0, -1, 1'b0, 1'b1, 4, 1};   // done one poll too late

      repeat (3) @(negedge clk);
      check("reset status", {busy, done, timeout, move_valid, move_data, move_count}, 0);
      check("reset bus", {master_read, master_write, master_address, master_writedata}, 0);
      check("byteenable", master_byteenable, 4'hF);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) runScenario(tbl[i], $sformatf("tbl%0d", i));

      resetMidMove();
      runScenario(tbl[0], "post-reset");

      for (int r = 0; r < 8; r++) begin : g_rand
         scen_t s;
         s.waitCyc    = $urandom_range(0, 3);
         s.latency    = $urandom_range(1, 4);
         s.pollsDone  = $urandom_range(0, 5);
         s.count      = $urandom_range(0, 10);
         s.readyStall = $urandom_range(0, 3);
         s.goAgain    = -1;
         s.fixedMoves = 1'b0;
         s.expTimeout = (s.pollsDone == 0) || (s.pollsDone > PL);
         s.expPolls   = s.expTimeout ? PL : s.pollsDone;
         s.expDone    = 1;
         runScenario(s, $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
`default_nettype wire
